// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between the CPU and the
// debug/loader port; one transaction in flight, fixed read latency MEM_LAT.
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_prio,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_e;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_e              state_q;
  owner_e              owner_q;
  owner_e              last_owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          lat_cnt_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic                cpu_done_q;
  logic                dbg_done_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   dbg_rdata_q;

  logic any_req;
  logic win_dbg;
  logic idle_gnt;

  // Grant is a Mealy output of IDLE; it is masked by reset so every output
  // reads zero as soon as reset is asserted.
  always_comb begin
    any_req  = cpu_req | dbg_req;
    win_dbg  = dbg_req & (~cpu_req | dbg_prio | (last_owner_q == OWN_CPU));
    idle_gnt = (state_q == IDLE) & ~reset;
    cpu_gnt  = idle_gnt & cpu_req & ~win_dbg;
    dbg_gnt  = idle_gnt & win_dbg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DBG;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lat_cnt_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_done_q   <= 1'b0;
      dbg_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_done_q <= 1'b0;
      dbg_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q      <= win_dbg ? OWN_DBG : OWN_CPU;
            last_owner_q <= win_dbg ? OWN_DBG : OWN_CPU;
            we_q         <= win_dbg ? dbg_we    : cpu_we;
            addr_q       <= win_dbg ? dbg_addr  : cpu_addr;
            wdata_q      <= win_dbg ? dbg_wdata : cpu_wdata;
            mem_en_q     <= 1'b1;
            mem_we_q     <= win_dbg ? dbg_we : cpu_we;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          lat_cnt_q <= 3'd1;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt_q == LAT) begin
            if (owner_q == OWN_DBG) begin
              dbg_done_q <= 1'b1;
              if (!we_q) dbg_rdata_q <= mem_rdata;
            end else begin
              cpu_done_q <= 1'b1;
              if (!we_q) cpu_rdata_q <= mem_rdata;
            end
            state_q <= DONE;
          end else begin
            lat_cnt_q <= lat_cnt_q + 3'd1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_done  = cpu_done_q;
  assign dbg_done  = dbg_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two lanes (MEM_LAT=1 and 4) checked
// cycle by cycle against a transaction-level model with its own memory image.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   mode;   // 0 random, 1 both continuous prio=0, 2 both continuous prio=1

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_lane
    localparam int LAT = (k == 0) ? 1 : 4;

    logic       cpu_req, cpu_we, dbg_req, dbg_we, dbg_prio;
    logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [7:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic       cpu_gnt, cpu_done, dbg_gnt, dbg_done, mem_en, mem_we, busy;
    bit         in_access, in_wait;

    logic [7:0] phys [256];
    logic [7:0] refm [256];
    logic [7:0] exp_rd [2];
    int         c, rd_at, t_start;
    logic [7:0] rd_addr, t_addr, t_wdata;
    bit         active, last_dbg, t_dbg, t_we;
    bit         e_gc, e_gd, e_en, e_we, e_busy, e_dc, e_dd;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
      .dbg_prio(dbg_prio),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
    );

    initial begin
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      dbg_prio = 0; mem_rdata = 0;
      in_access = 0; in_wait = 0;
      c = 0; rd_at = -1; rd_addr = 0; t_start = 0;
      active = 0; last_dbg = 1; t_dbg = 0; t_we = 0; t_addr = 0; t_wdata = 0;
      exp_rd[0] = 0; exp_rd[1] = 0;
      for (int i = 0; i < 256; i++) begin
        phys[i] = 8'($urandom);
        refm[i] = phys[i];
      end
      forever begin
        @(negedge clk);
        e_gc = 0; e_gd = 0; e_en = 0; e_we = 0; e_busy = 0; e_dc = 0; e_dd = 0;
        in_access = 0; in_wait = 0;
        if (reset) begin
          active = 0; last_dbg = 1; exp_rd[0] = 0; exp_rd[1] = 0; rd_at = -1;
          check($sformatf("L%0d reset_addr", k), 32'({mem_addr, mem_wdata}), 32'd0);
        end else begin
          e_busy = active;
          if (active) begin
            if (c == t_start + 1) begin
              e_en = 1; e_we = t_we; in_access = 1;
              if (t_we) refm[t_addr] = t_wdata;
            end else if (c < t_start + LAT + 2) begin
              in_wait = 1;
            end
            check($sformatf("L%0d mem_addr", k), 32'(mem_addr), 32'(t_addr));
            check($sformatf("L%0d mem_wdata", k), 32'(mem_wdata), 32'(t_wdata));
            if (c == t_start + LAT + 2) begin
              if (t_dbg) e_dd = 1; else e_dc = 1;
              if (!t_we) exp_rd[t_dbg] = refm[t_addr];
              active = 0;
            end
          end else if (cpu_req || dbg_req) begin
            if (cpu_req && dbg_req) t_dbg = dbg_prio ? 1'b1 : !last_dbg;
            else                    t_dbg = dbg_req;
            e_gd = t_dbg; e_gc = !t_dbg;
            t_we    = t_dbg ? dbg_we    : cpu_we;
            t_addr  = t_dbg ? dbg_addr  : cpu_addr;
            t_wdata = t_dbg ? dbg_wdata : cpu_wdata;
            t_start = c; active = 1; last_dbg = t_dbg;
          end
          if (mem_en) begin
            rd_at = c + LAT; rd_addr = mem_addr;
            if (mem_we) phys[mem_addr] = mem_wdata;
          end
        end
        check($sformatf("L%0d ctl{gc,gd,en,we,busy,dc,dd}", k),
              32'({cpu_gnt, dbg_gnt, mem_en, mem_we, busy, cpu_done, dbg_done}),
              32'({e_gc, e_gd, e_en, e_we, e_busy, e_dc, e_dd}));
        check($sformatf("L%0d cpu_rdata", k), 32'(cpu_rdata), 32'(exp_rd[0]));
        check($sformatf("L%0d dbg_rdata", k), 32'(dbg_rdata), 32'(exp_rd[1]));
        c++;

        @(posedge clk);
        #1;
        if (reset) begin
          cpu_req = 1; dbg_req = 1; dbg_prio = 0;
          cpu_we = 8'($urandom) < 8'd128; cpu_addr = 8'h20 + 8'($urandom_range(0, 7)); cpu_wdata = 8'($urandom);
          dbg_we = 8'($urandom) < 8'd128; dbg_addr = 8'h20 + 8'($urandom_range(0, 7)); dbg_wdata = 8'($urandom);
        end else begin
          // Requesters hold their fields until granted, then may re-request.
          if (!cpu_req || e_gc) begin
            cpu_req   = (mode != 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            cpu_we    = ($urandom_range(0, 1) == 1);
            cpu_addr  = 8'h20 + 8'($urandom_range(0, 7));
            cpu_wdata = 8'($urandom);
          end
          if (!dbg_req || e_gd) begin
            dbg_req   = (mode != 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            dbg_we    = ($urandom_range(0, 1) == 1);
            dbg_addr  = 8'h20 + 8'($urandom_range(0, 7));
            dbg_wdata = 8'($urandom);
          end
          dbg_prio = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : ($urandom_range(0, 1) == 1);
        end
        mem_rdata = (c == rd_at) ? phys[rd_addr] : 8'($urandom);
      end
    end
  end

  initial begin
    mode  = 0;
    reset = 1;
    repeat (3) @(posedge clk);
    #3 reset = 0;
    repeat (400) @(posedge clk);
    mode = 1;
    repeat (100) @(posedge clk);
    for (int t = 0; t < 2; t++) begin
      int n;
      bit hit;
      n = 0; hit = 0;
      while (!hit && n < 100) begin
        @(negedge clk);
        #2;
        hit = (t == 0) ? g_lane[1].in_access : g_lane[1].in_wait;
        n++;
      end
      check("rst_window", 32'(hit), 32'd1);
      reset = 1;
      #1;
      check("rst_async", 32'({g_lane[1].mem_en, g_lane[1].busy, g_lane[1].cpu_gnt,
                              g_lane[1].dbg_gnt, g_lane[1].cpu_done, g_lane[1].dbg_done}), 32'd0);
      repeat (2) @(posedge clk);
      #3 reset = 0;
      repeat (40) @(posedge clk);
    end
    mode = 2;
    repeat (100) @(posedge clk);
    mode = 0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
